// File: rtl/mem_load_ctrl.sv
// Serial host loader for the instruction/data caches: decodes 13-bit MSB-first
// frames into single-word cache writes or serial readback of one cache word.
module mem_load_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csi_n,
  input  logic              csd_n,
  input  logic              mosi,
  input  logic              proc_done_i,
  input  logic [DATA_W-1:0] icache_rdata_i,
  input  logic [DATA_W-1:0] dcache_rdata_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              icache_wen_o,
  output logic              dcache_wen_o,
  output logic              host_sel_o,
  output logic              miso,
  output logic              frame_err_o,
  output logic [7:0]        wr_count_o
);

  localparam int unsigned FRAME_W   = 1 + ADDR_W + DATA_W;
  localparam int unsigned READ_BITS = 1 + ADDR_W;
  localparam int unsigned CNT_W     = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_READ,
    S_SEND,
    S_WRITE,
    S_WAIT_CS
  } state_e;

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                tgt_q, tgt_d;     // 1 = dcache, 0 = icache
  logic                err_q, err_d;
  logic [7:0]          wr_count_q, wr_count_d;
  logic                csi_prev_q, csd_prev_q;

  logic                cs_tgt;
  logic                other_fall;
  logic [FRAME_W-1:0]  sr_shift;
  logic [CNT_W-1:0]    cnt_inc;

  assign cs_tgt     = tgt_q ? csd_n : csi_n;
  assign other_fall = tgt_q ? (csi_prev_q & ~csi_n) : (csd_prev_q & ~csd_n);
  assign sr_shift   = {sr_q[FRAME_W-2:0], mosi};
  assign cnt_inc    = cnt_q + CNT_W'(1);

  // State and datapath registers; chip-select history resets to deselected
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      tx_q       <= '0;
      tgt_q      <= 1'b0;
      err_q      <= 1'b0;
      wr_count_q <= '0;
      csi_prev_q <= 1'b1;
      csd_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      tgt_q      <= tgt_d;
      err_q      <= err_d;
      wr_count_q <= wr_count_d;
      csi_prev_q <= csi_n;
      csd_prev_q <= csd_n;
    end
  end

  // Next state and cache-side strobes; cache accesses occur within the state cycle
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    tx_d         = tx_q;
    tgt_d        = tgt_q;
    err_d        = err_q;
    wr_count_d   = wr_count_q;
    host_sel_o   = 1'b0;
    icache_wen_o = 1'b0;
    dcache_wen_o = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    miso         = 1'b0;

    if (state_q != S_IDLE && other_fall) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (!csi_n && !csd_n) begin
          err_d   = 1'b1;
          state_d = S_WAIT_CS;
        end else if (!csi_n || !csd_n) begin
          tgt_d   = csi_n;
          sr_d    = FRAME_W'(mosi);
          cnt_d   = CNT_W'(1);
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (cs_tgt) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          sr_d  = sr_shift;
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(READ_BITS) && !sr_shift[ADDR_W]) begin
            state_d = S_READ;
          end else if (cnt_inc == CNT_W'(FRAME_W)) begin
            state_d = S_WRITE;
          end
        end
      end

      S_READ: begin
        if (proc_done_i) begin
          host_sel_o = 1'b1;
          mem_addr_o = sr_q[ADDR_W-1:0];
          tx_d       = tgt_q ? dcache_rdata_i : icache_rdata_i;
        end else begin
          tx_d  = '0;
          err_d = 1'b1;
        end
        cnt_d   = '0;
        state_d = S_SEND;
      end

      S_SEND: begin
        miso  = tx_q[DATA_W-1];
        tx_d  = {tx_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_inc;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = S_WAIT_CS;
        end
      end

      S_WRITE: begin
        if (proc_done_i && sr_q[FRAME_W-1]) begin
          host_sel_o   = 1'b1;
          mem_addr_o   = sr_q[FRAME_W-2 -: ADDR_W];
          mem_wdata_o  = sr_q[DATA_W-1:0];
          icache_wen_o = ~tgt_q;
          dcache_wen_o = tgt_q;
          wr_count_d   = wr_count_q + 8'd1;
        end else begin
          err_d = 1'b1;
        end
        state_d = S_WAIT_CS;
      end

      S_WAIT_CS: begin
        if (csi_n && csd_n) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign frame_err_o = err_q;
  assign wr_count_o  = wr_count_q;

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Directed + randomized bench for mem_load_ctrl: frame-level reference model
// with behavioural cache memories and strobe counters.
module tb_mem_load_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       csi_n, csd_n, mosi, proc_done_i;
  logic [7:0] icache_rdata_i, dcache_rdata_i;
  logic [3:0] mem_addr_o;
  logic [7:0] mem_wdata_o;
  logic       icache_wen_o, dcache_wen_o, host_sel_o, miso, frame_err_o;
  logic [7:0] wr_count_o;

  mem_load_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .csi_n(csi_n), .csd_n(csd_n), .mosi(mosi),
    .proc_done_i(proc_done_i), .icache_rdata_i(icache_rdata_i),
    .dcache_rdata_i(dcache_rdata_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .icache_wen_o(icache_wen_o),
    .dcache_wen_o(dcache_wen_o), .host_sel_o(host_sel_o), .miso(miso),
    .frame_err_o(frame_err_o), .wr_count_o(wr_count_o)
  );

  always #5 clk = ~clk;

  // Behavioural caches: asynchronous read, written on wen or by bench preload
  logic [7:0] imem [16];
  logic [7:0] dmem [16];
  logic       env_ld = 1'b0;
  logic       env_ld_sel = 1'b0;
  logic [3:0] env_ld_addr = '0;
  logic [7:0] env_ld_data = '0;
  int         n_iwen = 0;
  int         n_dwen = 0;

  assign icache_rdata_i = imem[mem_addr_o];
  assign dcache_rdata_i = dmem[mem_addr_o];

  always @(posedge clk) begin
    if (env_ld) begin
      if (env_ld_sel) dmem[env_ld_addr] <= env_ld_data;
      else            imem[env_ld_addr] <= env_ld_data;
    end else begin
      if (icache_wen_o) begin
        imem[mem_addr_o] <= mem_wdata_o;
        n_iwen <= n_iwen + 1;
      end
      if (dcache_wen_o) begin
        dmem[mem_addr_o] <= mem_wdata_o;
        n_dwen <= n_dwen + 1;
      end
    end
  end

  // Reference model state
  logic [7:0] ref_i [16];
  logic [7:0] ref_d [16];
  logic [7:0] exp_cnt;
  logic       exp_err;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] all_outs();
    return {host_sel_o, icache_wen_o, dcache_wen_o, miso, mem_addr_o,
            mem_wdata_o, wr_count_o, frame_err_o};
  endfunction

  task automatic preload(input logic sel, input logic [3:0] a, input logic [7:0] d);
    env_ld = 1'b1; env_ld_sel = sel; env_ld_addr = a; env_ld_data = d;
    @(negedge clk);
    env_ld = 1'b0;
    if (sel) ref_d[a] = d; else ref_i[a] = d;
  endtask

  task automatic reset_dut();
    rst = 1'b1; csi_n = 1'b1; csd_n = 1'b1; mosi = 1'b0; proc_done_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    exp_err = 1'b0;
  endtask

  // Drive frame bits first..last; sel[0] pulls csi_n low, sel[1] pulls csd_n low
  task automatic drive_bits(input logic [1:0] sel, input logic [12:0] f,
                            input int first, input int last, input logic pd_last);
    for (int i = first; i <= last; i++) begin
      csi_n = ~sel[0];
      csd_n = ~sel[1];
      mosi  = f[12-i];
      proc_done_i = (i == last) ? pd_last : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic release_cs();
    csi_n = 1'b1; csd_n = 1'b1; mosi = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle_outs", {host_sel_o, icache_wen_o, dcache_wen_o, miso}, 0);
  endtask

  task automatic do_write(input logic t, input logic [3:0] a, input logic [7:0] d, input logic pd);
    int bi, bd;
    bi = n_iwen; bd = n_dwen;
    drive_bits(t ? 2'b10 : 2'b01, {1'b1, a, d}, 0, 12, pd);
    check("wr_host_sel", host_sel_o, pd);
    check("wr_iwen", icache_wen_o, pd & ~t);
    check("wr_dwen", dcache_wen_o, pd & t);
    if (pd) begin
      check("wr_addr", mem_addr_o, a);
      check("wr_data", mem_wdata_o, d);
      if (t) ref_d[a] = d; else ref_i[a] = d;
      exp_cnt++;
    end else begin
      exp_err = 1'b1;
    end
    mosi = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("wr_count", wr_count_o, exp_cnt);
    check("wr_err", frame_err_o, exp_err);
    check("wr_ipulses", n_iwen - bi, pd & ~t);
    check("wr_dpulses", n_dwen - bd, pd & t);
    release_cs();
  endtask

  task automatic do_read(input logic t, input logic [3:0] a, input logic pd);
    logic [7:0] exp_tx;
    int bi, bd;
    bi = n_iwen; bd = n_dwen;
    drive_bits(t ? 2'b10 : 2'b01, {1'b0, a, 8'h00}, 0, 4, pd);
    check("rd_host_sel", host_sel_o, pd);
    if (pd) check("rd_addr", mem_addr_o, a);
    exp_tx = pd ? (t ? ref_d[a] : ref_i[a]) : 8'h00;
    if (!pd) exp_err = 1'b1;
    for (int j = 7; j >= 0; j--) begin
      mosi = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("rd_miso_b%0d", j), miso, exp_tx[j]);
    end
    @(negedge clk);
    check("rd_miso_after", miso, 0);
    check("rd_err", frame_err_o, exp_err);
    check("rd_no_wen", (n_iwen - bi) + (n_dwen - bd), 0);
    release_cs();
  endtask

  initial begin
    int bi, bd;
    logic t, op, pd;
    logic [3:0] a;
    logic [7:0] d;

    rst = 1'b1; csi_n = 1'b1; csd_n = 1'b1; mosi = 1'b0; proc_done_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      preload(1'b0, 4'(k), 8'($urandom));
      preload(1'b1, 4'(k), 8'($urandom));
    end
    reset_dut();
    check("reset_outs", all_outs(), 0);

    // Directed write to icache and read from dcache
    do_write(1'b0, 4'h3, 8'hA5, 1'b1);
    check("dir_wr_count", wr_count_o, 1);
    check("dir_wr_err", frame_err_o, 0);
    preload(1'b1, 4'h5, 8'h3C);
    do_read(1'b1, 4'h5, 1'b1);

    // Randomized frame mix
    for (int n = 0; n < 40; n++) begin
      t  = 1'($urandom_range(0, 1));
      op = 1'($urandom_range(0, 1));
      a  = 4'($urandom);
      d  = 8'($urandom);
      pd = ($urandom_range(0, 7) != 0);
      if (op) do_write(t, a, d, pd);
      else    do_read(t, a, pd);
    end
    for (int k = 0; k < 16; k++) begin
      check($sformatf("imem_%0d", k), imem[k], ref_i[k]);
      check($sformatf("dmem_%0d", k), dmem[k], ref_d[k]);
    end

    // Write refused while processor busy
    reset_dut();
    do_write(1'b1, 4'h7, 8'h5A, 1'b0);
    check("busy_count", wr_count_o, 0);

    // Early CS release aborts, next frame still commits
    reset_dut();
    bi = n_iwen; bd = n_dwen;
    drive_bits(2'b10, {1'b1, 4'h2, 8'h99}, 0, 6, 1'b1);
    csd_n = 1'b1;
    @(negedge clk);
    check("abort_err", frame_err_o, 1);
    check("abort_no_wen", (n_iwen - bi) + (n_dwen - bd), 0);
    exp_err = 1'b1;
    do_write(1'b1, 4'h2, 8'h77, 1'b1);

    // Both chip selects together
    reset_dut();
    bi = n_iwen; bd = n_dwen;
    drive_bits(2'b11, {1'b1, 4'h1, 8'h11}, 0, 12, 1'b1);
    check("both_err", frame_err_o, 1);
    check("both_host_sel", host_sel_o, 0);
    check("both_no_wen", (n_iwen - bi) + (n_dwen - bd), 0);
    release_cs();
    exp_err = 1'b1;
    do_read(1'b0, 4'($urandom), 1'b1);

    // Other CS falling mid-frame flags error but frame completes
    reset_dut();
    drive_bits(2'b10, {1'b1, 4'hB, 8'h3E}, 0, 2, 1'b1);
    drive_bits(2'b11, {1'b1, 4'hB, 8'h3E}, 3, 12, 1'b1);
    check("glitch_dwen", dcache_wen_o, 1);
    check("glitch_iwen", icache_wen_o, 0);
    check("glitch_err", frame_err_o, 1);
    ref_d[4'hB] = 8'h3E;
    @(negedge clk);
    check("glitch_count", wr_count_o, 1);
    release_cs();
    check("glitch_mem", dmem[4'hB], 8'h3E);

    // 256 writes wrap the counter
    reset_dut();
    for (int n = 0; n < 256; n++) begin
      do_write(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 1'b1);
    end
    check("wrap_count", wr_count_o, 0);

    // Reset in the middle of a write frame
    reset_dut();
    bi = n_iwen; bd = n_dwen;
    drive_bits(2'b01, {1'b1, 4'h6, 8'hC3}, 0, 9, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outs", all_outs(), 0);
    rst = 1'b0; csi_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_outs_after", all_outs(), 0);
    check("rst_mid_no_wen", (n_iwen - bi) + (n_dwen - bd), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_load_ctrl.md
MEM_LOAD_CTRL -- requirements
Module: mem_load_ctrl

Interface
REQ-001 Clock clk; reset rst, synchronous, active-high.
REQ-002 Parameters: DATA_W default 8, data word width; ADDR_W default 4, cache address width.
REQ-003 clk  in  1  system clock; all inputs sampled on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 csi_n  in  1  host chip select, instruction cache, active low.
REQ-006 csd_n  in  1  host chip select, data cache, active low.
REQ-007 mosi  in  1  host serial data, one bit per clk while selected, MSB first.
REQ-008 proc_done_i  in  1  processor idle; host cache access permitted only when high.
REQ-009 icache_rdata_i / dcache_rdata_i  in  DATA_W each  asynchronous cache read data.
REQ-010 mem_addr_o  out  ADDR_W  cache address driven to the selected cache.
REQ-011 mem_wdata_o  out  DATA_W  cache write data.
REQ-012 icache_wen_o / dcache_wen_o  out  1 each  single-cycle write strobes.
REQ-013 host_sel_o  out  1  high while controller owns the cache address mux (READ, WRITE states).
REQ-014 miso  out  1  host serial read data, MSB first.
REQ-015 frame_err_o  out  1  sticky error flag, cleared only by rst.
REQ-016 wr_count_o  out  8  count of committed writes, wraps 255->0.

Function
REQ-017 Frame: 13 bits, MSB first: op (1=write, 0=read), addr[3:0], data[7:0]; target is icache if csi_n low, dcache if csd_n low.
REQ-018 States: IDLE, SHIFT, READ, SEND, WRITE, WAIT_CS.
REQ-019 IDLE: exactly one CS low -> latch target, shift current mosi as bit 0, go SHIFT; both CS low -> set frame_err_o, go WAIT_CS; neither -> stay.
REQ-020 SHIFT: each cycle with latched CS low shifts mosi into a 13-bit register, with bit counter 0..12.
REQ-021 CS rising in SHIFT before the frame is complete -> set frame_err_o, no cache access, go IDLE.
REQ-022 Other CS falling during any non-IDLE state -> set frame_err_o; the current frame continues.
REQ-023 Read: when 5th bit captured and op=0 -> go READ.
REQ-024 READ (1 cycle): if proc_done_i=1, host_sel_o=1 and mem_addr_o=addr; capture the target cache rdata into 8-bit tx register; go SEND. If proc_done_i=0, load tx=8'h00, set frame_err_o, go SEND.
REQ-025 SEND: 8 cycles; miso=tx[7], tx shifts left each cycle; mosi ignored; then go WAIT_CS.
REQ-026 Write: when 13th bit captured and op=1 -> go WRITE.
REQ-027 WRITE (1 cycle): if proc_done_i=1, host_sel_o=1, drive addr/data, pulse selected wen for exactly one cycle, wr_count_o+1; else set frame_err_o with no wen; go WAIT_CS.
REQ-028 WAIT_CS: stay until both CS high, then IDLE; extra mosi bits are ignored.
REQ-029 miso=0 outside SEND; wen never asserted outside WRITE; wen never asserted when proc_done_i=0.
REQ-030 proc_done_i falling mid-frame does not abort; it is only sampled in READ/WRITE.
REQ-031 Latency: write strobe in the cycle after the 13th bit; first miso bit in the cycle after READ.

Reset
REQ-032 rst takes effect at the next edge from any state: state=IDLE; shift register, counter, tx, wr_count_o, frame_err_o=0; all wen, host_sel_o, miso, mem_addr_o, mem_wdata_o=0.
REQ-033 Frame in progress at reset is discarded with no cache write.

Verification
REQ-034 csi_n low, bits 1_0011_10100101, proc_done_i=1 -> icache_wen_o one cycle, addr 4'h3, data 8'hA5, wr_count_o=1, frame_err_o=0.
REQ-035 csd_n low, bits 0_0101, dcache_rdata_i=8'h3C at addr 5 -> miso sequence 0,0,1,1,1,1,0,0 over 8 cycles, no wen.
REQ-036 Write frame with proc_done_i=0 in WRITE -> no wen, frame_err_o=1, wr_count_o unchanged.
REQ-037 csd_n released after 7 bits -> frame_err_o=1, returns IDLE, next valid frame commits normally.
REQ-038 csi_n and csd_n asserted together -> frame_err_o=1, no access until both high.
REQ-039 256 valid writes -> wr_count_o=0; rst asserted after bit 10 of a write -> no wen, all outputs 0.
